// File: rtl/memory_access_unit.sv
// memory_access_unit
//   Load/store unit for the memory stage. It takes one access at a time from
//   execute over a valid/ready handshake, drives one word-aligned request on
//   the data-memory bus, and formats the load result for writeback.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined   : misaligned H/W accesses are dropped (no bus request) and
//                 misalign_err pulses for one cycle.
//     undefined : misalign_err is tied low; the low address bits of H/W
//                 accesses are ignored and the access proceeds normally.
//
//   Ports
//     clk, rst                 clock (rising edge), async active-high reset
//     mem_valid / mem_ready    access handshake from execute
//     mem_write, mem_funct3    store flag; [1:0] size B/H/W, [2] unsigned load
//     mem_addr, mem_wdata      byte address, right-justified store data
//     dmem_req/we/addr/be/wdata  registered bus request fields
//     dmem_gnt, dmem_rvalid, dmem_rdata  bus grant and read return
//     dm_read_data             formatted load result, held until next load
//     load_done, store_done    one-cycle completion pulses
//     misalign_err             one-cycle pulse for a dropped access
//     mem_busy                 stall to pipeline (inverse of mem_ready)
//
//   state  | meaning
//   S_IDLE | ready for a new access
//   S_REQ  | request on the bus, waiting for grant
//   S_WAIT | load granted, waiting for read data
module memory_access_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic            mem_write,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] dm_read_data,
    output logic            load_done,
    output logic            store_done,
    output logic            misalign_err,
    output logic            mem_busy
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_off;

    logic [1:0]      in_off;
    logic            in_misalign;
    logic [3:0]      in_be;
    logic [XLEN-1:0] in_wdata;

    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] fmt_data;

    assign mem_ready = (state == S_IDLE);
    assign mem_busy  = ~mem_ready;

    // Effective lane offset: halfwords ignore addr[0], words ignore addr[1:0].
    // When misaligned accesses trap they never reach the bus, so the same
    // offset works for both builds.
    always_comb begin
        in_off      = mem_addr[1:0];
        in_misalign = 1'b0;
        if (mem_funct3[1]) begin
            in_off = 2'b00;
        end else if (mem_funct3[0]) begin
            in_off = {mem_addr[1], 1'b0};
        end
`ifdef MISALIGN_TRAP_EN
        if (mem_funct3[1]) begin
            in_misalign = (mem_addr[1:0] != 2'b00);
        end else if (mem_funct3[0]) begin
            in_misalign = mem_addr[0];
        end
`endif
    end

    always_comb begin
        in_be    = 4'b1111;
        in_wdata = '0;
        if (mem_write) begin
            if (mem_funct3[1]) begin
                in_wdata = mem_wdata;
            end else if (mem_funct3[0]) begin
                in_be    = in_off[1] ? 4'b1100 : 4'b0011;
                in_wdata = {2{mem_wdata[15:0]}};
            end else begin
                in_be    = 4'b0001 << in_off;
                in_wdata = {4{mem_wdata[7:0]}};
            end
        end
    end

    always_comb begin
        rd_byte  = 8'(dmem_rdata >> {lat_off, 3'b000});
        rd_half  = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        fmt_data = dmem_rdata;
        if (!lat_size[1]) begin
            if (lat_size[0]) begin
                fmt_data = lat_unsigned ? {16'h0000, rd_half}
                                        : {{16{rd_half[15]}}, rd_half};
            end else begin
                fmt_data = lat_unsigned ? {24'h000000, rd_byte}
                                        : {{24{rd_byte[7]}}, rd_byte};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_off      <= 2'b00;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= 4'b0000;
            dmem_wdata   <= '0;
            dm_read_data <= '0;
            load_done    <= 1'b0;
            store_done   <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            load_done    <= 1'b0;
            store_done   <= 1'b0;
            misalign_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_valid) begin
                        lat_write    <= mem_write;
                        lat_size     <= mem_funct3[1:0];
                        lat_unsigned <= mem_funct3[2];
                        lat_off      <= in_off;
                        if (in_misalign) begin
                            misalign_err <= 1'b1;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {mem_addr[XLEN-1:2], 2'b00};
                            dmem_be    <= in_be;
                            dmem_wdata <= in_wdata;
                            state      <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (lat_write) begin
                            store_done <= 1'b1;
                            state      <= S_IDLE;
                        end else if (dmem_rvalid) begin
                            dm_read_data <= fmt_data;
                            load_done    <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        dm_read_data <= fmt_data;
                        load_done    <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] dm_read_data;
    logic        load_done;
    logic        store_done;
    logic        misalign_err;
    logic        mem_busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_rd;

    memory_access_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_write    (mem_write),
        .mem_funct3   (mem_funct3),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .dm_read_data (dm_read_data),
        .load_done    (load_done),
        .store_done   (store_done),
        .misalign_err (misalign_err),
        .mem_busy     (mem_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        mem_valid  = 1'b1;
        mem_write  = wr;
        mem_funct3 = f3;
        mem_addr   = addr;
        mem_wdata  = wd;
        tick();
        mem_valid  = 1'b0;
    endtask

    // gap=0: grant and read data in the same cycle; gap>0: rvalid that many cycles after grant
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp_addr, input logic [31:0] rdata,
                            input int gap, input logic [31:0] exp);
        present(1'b0, f3, addr, 32'h0);
        check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
        check({tag, "_addr"}, dmem_addr, exp_addr);
        check({tag, "_be"}, {28'd0, dmem_be}, 32'hF);
        check({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
        check({tag, "_ready"}, {31'd0, mem_ready}, 32'd0);
        dmem_gnt = 1'b1;
        if (gap == 0) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
        end
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (gap > 0) begin
            check({tag, "_req_drop"}, {31'd0, dmem_req}, 32'd0);
            check({tag, "_early_done"}, {31'd0, load_done}, 32'd0);
            repeat (gap - 1) tick();
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
            tick();
            dmem_rvalid = 1'b0;
        end
        check({tag, "_done"}, {31'd0, load_done}, 32'd1);
        check({tag, "_data"}, dm_read_data, exp);
        tick();
        check({tag, "_done_clr"}, {31'd0, load_done}, 32'd0);
        check({tag, "_idle"}, {31'd0, mem_ready}, 32'd1);
        last_rd = exp;
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd);
        present(1'b1, f3, addr, wd);
        check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
        check({tag, "_we"}, {31'd0, dmem_we}, 32'd1);
        check({tag, "_addr"}, dmem_addr, exp_addr);
        check({tag, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
        check({tag, "_wdata"}, dmem_wdata, exp_wd);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check({tag, "_done"}, {31'd0, store_done}, 32'd1);
        check({tag, "_req_drop"}, {31'd0, dmem_req}, 32'd0);
        check({tag, "_rd_hold"}, dm_read_data, last_rd);
        tick();
        check({tag, "_done_clr"}, {31'd0, store_done}, 32'd0);
        check({tag, "_idle"}, {31'd0, mem_ready}, 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        mem_valid   = 1'b0;
        mem_write   = 1'b0;
        mem_funct3  = 3'b000;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        last_rd     = 32'h0;

        #12;
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_rd", dm_read_data, 32'd0);
        check("rst_ready", {31'd0, mem_ready}, 32'd1);
        check("rst_busy", {31'd0, mem_busy}, 32'd0);
        check("rst_pulses", {29'd0, load_done, store_done, misalign_err}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // LW with rvalid two cycles after grant
        run_load("lw100", 3'b010, 32'h100, 32'h100, 32'hDEADBEEF, 2, 32'hDEADBEEF);

        // sub-word loads, minimum latency (grant and rvalid together)
        run_load("lb103", 3'b000, 32'h103, 32'h100, 32'h80FF1234, 0, 32'hFFFFFF80);
        run_load("lbu103", 3'b100, 32'h103, 32'h100, 32'h80FF1234, 0, 32'h00000080);
        run_load("lb101", 3'b000, 32'h101, 32'h100, 32'h80FF1234, 0, 32'h00000012);
        run_load("lh102", 3'b001, 32'h102, 32'h100, 32'h80FF1234, 0, 32'hFFFF80FF);
        run_load("lh100", 3'b001, 32'h100, 32'h100, 32'h80FF1234, 1, 32'h00001234);
        run_load("lhu102", 3'b101, 32'h102, 32'h100, 32'h80FF1234, 0, 32'h000080FF);
        run_load("lwu", 3'b110, 32'h104, 32'h104, 32'h8000_0001, 0, 32'h8000_0001);

        // stores
        run_store("sh202", 3'b001, 32'h202, 32'h0000ABCD, 32'h200, 4'b1100, 32'hABCDABCD);
        run_store("sh200", 3'b001, 32'h200, 32'h12345678, 32'h200, 4'b0011, 32'h56785678);
        run_store("sb201", 3'b000, 32'h201, 32'hFFFFFF55, 32'h200, 4'b0010, 32'h55555555);
        run_store("sb203", 3'b000, 32'h203, 32'h000000A7, 32'h200, 4'b1000, 32'hA7A7A7A7);
        run_store("sw204", 3'b010, 32'h204, 32'hCAFEF00D, 32'h204, 4'b1111, 32'hCAFEF00D);

        // grant stall with mem_valid held high and a stray rvalid before grant
        mem_valid  = 1'b1;
        mem_write  = 1'b0;
        mem_funct3 = 3'b010;
        mem_addr   = 32'h300;
        tick();
        mem_addr   = 32'h444;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = 32'h0BADBAD0;
            end
            tick();
            dmem_rvalid = 1'b0;
            check("stall_req", {31'd0, dmem_req}, 32'd1);
            check("stall_addr", dmem_addr, 32'h300);
            check("stall_be", {28'd0, dmem_be}, 32'hF);
            check("stall_ready", {31'd0, mem_ready}, 32'd0);
            check("stall_busy", {31'd0, mem_busy}, 32'd1);
            check("stall_nodone", {31'd0, load_done}, 32'd0);
        end
        mem_valid   = 1'b0;
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h13579BDF;
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        check("stall_done", {31'd0, load_done}, 32'd1);
        check("stall_data", dm_read_data, 32'h13579BDF);
        last_rd = 32'h13579BDF;
        tick();
        check("stall_noreissue", {31'd0, dmem_req}, 32'd0);

        // reset while the request is on the bus
        present(1'b0, 3'b010, 32'h400, 32'h0);
        check("rstreq_pre", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstreq_req", {31'd0, dmem_req}, 32'd0);
        check("rstreq_ready", {31'd0, mem_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // reset while waiting for read data
        present(1'b0, 3'b010, 32'h500, 32'h0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check("rstwait_busy", {31'd0, mem_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstwait_req", {31'd0, dmem_req}, 32'd0);
        check("rstwait_ready", {31'd0, mem_ready}, 32'd1);
        rst = 1'b0;
        last_rd = 32'h0;
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h77777777;
        tick();
        dmem_rvalid = 1'b0;
        check("rstwait_nodone", {31'd0, load_done}, 32'd0);
        check("rstwait_rd", dm_read_data, 32'h0);
        check("rstwait_idle", {31'd0, mem_ready}, 32'd1);

`ifdef MISALIGN_TRAP_EN
        present(1'b0, 3'b010, 32'h102, 32'h0);
        check("mis_lw_err", {31'd0, misalign_err}, 32'd1);
        check("mis_lw_req", {31'd0, dmem_req}, 32'd0);
        check("mis_lw_ready", {31'd0, mem_ready}, 32'd1);
        tick();
        check("mis_lw_err_clr", {31'd0, misalign_err}, 32'd0);
        check("mis_lw_nodone", {31'd0, load_done}, 32'd0);
        check("mis_lw_rd", dm_read_data, last_rd);
        present(1'b1, 3'b001, 32'h201, 32'h1111);
        check("mis_sh_err", {31'd0, misalign_err}, 32'd1);
        check("mis_sh_req", {31'd0, dmem_req}, 32'd0);
        tick();
        check("mis_sh_nodone", {31'd0, store_done}, 32'd0);
        run_load("mis_lh_ok", 3'b001, 32'h102, 32'h100, 32'h80FF1234, 0, 32'hFFFF80FF);
`else
        run_load("nomis_lw", 3'b010, 32'h102, 32'h100, 32'h11223344, 0, 32'h11223344);
        check("nomis_err", {31'd0, misalign_err}, 32'd0);
        run_load("nomis_lh", 3'b001, 32'h103, 32'h100, 32'h80FF1234, 0, 32'hFFFF80FF);
        run_store("nomis_sh", 3'b001, 32'h201, 32'h0000BEEF, 32'h200, 4'b0011, 32'hBEEFBEEF);
        check("nomis_err2", {31'd0, misalign_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
